// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB responder with a simple register port (OV7670-style camera side)
//
// Purpose: decodes SCCB 3-phase write (ID, sub-addr, data), 2-phase write (ID, sub-addr)
// and 2-phase read (ID|1, data). ACK and read-data bits are driven on open-drain SDA.
//
// Ports:
//   i_clk        system clock; SCL/SDA are oversampled on it
//   i_rst        synchronous, active-high reset
//   i_scl        SCCB clock from the master (asynchronous)
//   io_sda       SCCB data, open drain: driven 0 or released (z)
//   i_reg_rdata  read data for o_reg_addr, sampled when a read byte is loaded
//   o_reg_addr   current sub-address
//   o_reg_wdata  last write data byte
//   o_reg_we     1-cycle write strobe, addr/wdata valid with it
//   o_busy       high from START until STOP
module sccb_slave #(
  parameter logic [7:0] DEVICE_ID = 8'h42
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic [7:0] i_reg_rdata,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_NA, S_IGNORE
  } state_t;

  logic       scl_meta_q, scl_s_q, scl_prev_q;
  logic       sda_meta_q, sda_s_q, sda_prev_q;
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rd_q;
  logic       ack_on_q;
  logic       sda_low_q;
  logic [7:0] reg_addr_q, reg_wdata_q;
  logic       reg_we_q, busy_q;

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] rx_byte_d;

  assign scl_rise  = scl_s_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q & scl_prev_q;
  assign start_det = scl_s_q & sda_prev_q & ~sda_s_q;
  assign stop_det  = scl_s_q & ~sda_prev_q & sda_s_q;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign rx_byte_d = {shift_q[6:0], sda_s_q};

  assign io_sda      = sda_low_q ? 1'b0 : 1'bz;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_reg_we    = reg_we_q;
  assign o_busy      = busy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchronizers reset to the idle bus level so no false edge follows reset.
      scl_meta_q  <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rd_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_low_q   <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_meta_q <= i_scl;
      scl_s_q    <= scl_meta_q;
      scl_prev_q <= scl_s_q;
      sda_meta_q <= io_sda;
      sda_s_q    <= sda_meta_q;
      sda_prev_q <= sda_s_q;
      reg_we_q   <= 1'b0;

      // Bus conditions win over any bit-level activity in the same cycle.
      if (start_det) begin
        state_q   <= S_ID;
        bit_cnt_q <= 3'd0;
        ack_on_q  <= 1'b0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        ack_on_q  <= 1'b0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_ID: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (rx_byte_d == DEVICE_ID) begin
                rd_q    <= 1'b0;
                state_q <= S_ID_ACK;
              end else if (rx_byte_d == (DEVICE_ID | 8'h01)) begin
                rd_q    <= 1'b1;
                state_q <= S_ID_ACK;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_SUB: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              reg_addr_q <= rx_byte_d;
              state_q    <= S_SUB_ACK;
            end
          end
          S_WDATA: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              reg_wdata_q <= rx_byte_d;
              reg_we_q    <= 1'b1;
              state_q     <= S_WDATA_ACK;
            end
          end
          // First fall after the 8th bit pulls SDA low; the next fall ends the ACK.
          S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_q  <= 1'b1;
              sda_low_q <= 1'b1;
            end else begin
              ack_on_q <= 1'b0;
              if (state_q == S_ID_ACK && rd_q) begin
                // Release fall doubles as the first read-bit drive edge.
                shift_q   <= i_reg_rdata;
                sda_low_q <= ~i_reg_rdata[7];
                state_q   <= S_RDATA;
              end else begin
                sda_low_q <= 1'b0;
                case (state_q)
                  S_ID_ACK:  state_q <= S_SUB;
                  S_SUB_ACK: state_q <= S_WDATA;
                  default:   state_q <= S_IGNORE;
                endcase
              end
            end
          end
          // bit_cnt_q counts falls here: 7 more drives, then release on the 8th.
          S_RDATA: if (scl_fall) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              sda_low_q <= 1'b0;
              state_q   <= S_RD_NA;
            end else begin
              shift_q   <= {shift_q[6:0], 1'b0};
              sda_low_q <= ~shift_q[6];
            end
          end
          S_RD_NA: if (scl_rise) state_q <= S_IGNORE;
          default: sda_low_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - directed self-checking bench for sccb_slave
module tb_sccb_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       master_low;
  logic [7:0] reg_rdata, reg_addr, reg_wdata;
  logic       reg_we, busy;
  wire        sda;

  pullup (sda);
  assign sda = master_low ? 1'b0 : 1'bz;

  // Register file stand-in: only address 8'h1A holds 8'hA5.
  assign reg_rdata = (reg_addr == 8'h1A) ? 8'hA5 : 8'h3C;

  always #5 clk = ~clk;

  sccb_slave #(.DEVICE_ID(8'h42)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_scl       (scl),
    .io_sda      (sda),
    .i_reg_rdata (reg_rdata),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_we    (reg_we),
    .o_busy      (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int slave_low_cnt = 0;
  logic [7:0] we_addr = 8'd0;
  logic [7:0] we_wdata = 8'd0;

  always @(posedge clk) begin
    if (reg_we) begin
      we_cnt   <= we_cnt + 1;
      we_addr  <= reg_addr;
      we_wdata <= reg_wdata;
    end
    if (sda === 1'b0 && !master_low) slave_low_cnt <= slave_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    master_low = ~b;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(10);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_start();
    master_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(10);
    master_low = 1'b1;
    wait_clk(10);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_stop();
    master_low = 1'b1;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(10);
    master_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    master_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(5);
    ack = (sda === 1'b0);
    wait_clk(5);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic read_byte(output logic [7:0] b);
    master_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(7);
      scl = 1'b1;
      wait_clk(5);
      b[i] = (sda !== 1'b0);
      wait_clk(5);
      scl = 1'b0;
    end
    send_bit(1'b1);
  endtask

  logic       ack;
  logic [7:0] rbyte;
  int         we_base, low_base;

  initial begin
    rst = 1'b1;
    scl = 1'b1;
    master_low = 1'b0;
    wait_clk(5);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);
    rst = 1'b0;
    wait_clk(10);

    // 1: 3-phase write 42/5F/73
    bus_start();
    chk("t1_busy", busy, 1'b1);
    write_byte(8'h42, ack); chk("t1_ack_id", ack, 1'b1);
    write_byte(8'h5F, ack); chk("t1_ack_sub", ack, 1'b1);
    write_byte(8'h73, ack); chk("t1_ack_data", ack, 1'b1);
    bus_stop();
    chk("t1_we_cnt", we_cnt, 1);
    chk("t1_we_addr", we_addr, 8'h5F);
    chk("t1_we_wdata", we_wdata, 8'h73);
    chk("t1_busy_stop", busy, 1'b0);

    // 2: back-to-back write 42/FF/0A
    bus_start();
    chk("t2_busy", busy, 1'b1);
    write_byte(8'h42, ack); chk("t2_ack_id", ack, 1'b1);
    write_byte(8'hFF, ack); chk("t2_ack_sub", ack, 1'b1);
    write_byte(8'h0A, ack); chk("t2_ack_data", ack, 1'b1);
    bus_stop();
    chk("t2_we_cnt", we_cnt, 2);
    chk("t2_we_addr", we_addr, 8'hFF);
    chk("t2_we_wdata", we_wdata, 8'h0A);

    // 3: foreign ID 60 -> never acked or written
    low_base = slave_low_cnt;
    we_base  = we_cnt;
    bus_start();
    write_byte(8'h60, ack); chk("t3_ack_id", ack, 1'b0);
    write_byte(8'h11, ack); chk("t3_ack_b1", ack, 1'b0);
    write_byte(8'h22, ack); chk("t3_ack_b2", ack, 1'b0);
    bus_stop();
    chk("t3_sda_low", slave_low_cnt - low_base, 0);
    chk("t3_we", we_cnt - we_base, 0);
    chk("t3_addr", reg_addr, 8'hFF);

    // 4: 2-phase write 42/1A, then read 43 -> A5
    we_base = we_cnt;
    bus_start();
    write_byte(8'h42, ack); chk("t4_ack_id", ack, 1'b1);
    write_byte(8'h1A, ack); chk("t4_ack_sub", ack, 1'b1);
    bus_stop();
    chk("t4_addr", reg_addr, 8'h1A);
    bus_start();
    write_byte(8'h43, ack); chk("t4_ack_rid", ack, 1'b1);
    read_byte(rbyte);
    bus_stop();
    chk("t4_rdata", rbyte, 8'hA5);
    chk("t4_we", we_cnt - we_base, 0);

    // 5: extra 4th byte is ignored
    we_base = we_cnt;
    bus_start();
    write_byte(8'h42, ack); chk("t5_ack_id", ack, 1'b1);
    write_byte(8'h10, ack); chk("t5_ack_sub", ack, 1'b1);
    write_byte(8'h20, ack); chk("t5_ack_data", ack, 1'b1);
    write_byte(8'h55, ack); chk("t5_ack_extra", ack, 1'b0);
    bus_stop();
    chk("t5_we", we_cnt - we_base, 1);
    chk("t5_addr", reg_addr, 8'h10);
    chk("t5_wdata", reg_wdata, 8'h20);

    // 6: reset during an ACK, then a START in the middle of a byte
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h42 >> i) & 1) != 0);
    master_low = 1'b0;
    wait_clk(2);
    chk("t6_ack_pre_rst", sda, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_sda_released", sda, 1'b1);
    wait_clk(2);
    chk("t6_rst_addr", reg_addr, 8'h00);
    chk("t6_rst_wdata", reg_wdata, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_we", reg_we, 1'b0);
    rst = 1'b0;
    wait_clk(10);
    we_base = we_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_start();
    write_byte(8'h42, ack); chk("t6_ack_id", ack, 1'b1);
    write_byte(8'h33, ack); chk("t6_ack_sub", ack, 1'b1);
    bus_stop();
    chk("t6_addr", reg_addr, 8'h33);
    chk("t6_we", we_cnt - we_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
